// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   Load/store unit for the MEM pipeline stage. Accepts the EX/MEM register
//   outputs, runs a req/ack handshake to a multi-cycle data bus, and returns
//   formatted load data for the MEM/WB register. The pipeline is stalled while
//   an access is in flight; misaligned or illegal accesses are dropped with a
//   one-cycle misalign pulse, and a bus that never acks is abandoned after
//   TIMEOUT_CYCLES request cycles with a one-cycle bus_err pulse.
//
// Ports
//   clk, reset              rising-edge clock, async active-low reset
//   mem_read, mem_write     access request from EX/MEM (write wins)
//   funct3                  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, store_data        byte address and rs2 store data
//   load_data               formatted load result (held until next load)
//   mem_stall               hold upstream stages, bubble into MEM/WB
//   misalign, bus_err       one-cycle error pulses
//   bus_req/we/addr/be/wdata  bus request side (stable while bus_req=1)
//   bus_ack, bus_rdata      bus completion and read word
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic          access, bad, start, timeout;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  // Extract the addressed byte/half and extend it according to funct3.
  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'b0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign access = mem_read | mem_write;
  assign bad    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
               || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
               || (funct3[1:0] == 2'b01 && addr[0]);
  assign start   = (state_q == IDLE) && access && !bad;
  assign timeout = (state_q == REQ) && !bus_ack && (cnt_q == CNT_LAST);

  // Store lane steering; reads always request the whole word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write) be_d = 4'b1111;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (bus_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'b0;
      bus_be    <= 4'b0;
      bus_wdata <= 32'b0;
      load_data <= 32'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            cnt_q     <= '0;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_d;
            bus_wdata <= wdata_d;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) load_data <= fmt_load(bus_rdata, f3_q, off_q);
          end else if (timeout) begin
            err_q <= 1'b1;
            if (!bus_we) load_data <= 32'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: err_q <= err_q;
      endcase
    end
  end

  // The reset term keeps the combinational stall/flag outputs low while reset
  // is asserted even if the EX/MEM inputs still present an access.
  assign bus_req   = (state_q == REQ);
  assign mem_stall = reset && (start || (state_q == REQ));
  assign misalign  = reset && (state_q == IDLE) && access && bad;
  assign bus_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'b0, store_data = 32'b0;
  logic [31:0] load_data;
  logic        mem_stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent access
  int          r_stalls, r_reqs;
  logic        r_misalign, r_err, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .mem_stall(mem_stall), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one access and play the bus: ack after `waits` request cycles
  // (never if waits >= TMO). Returns when mem_stall is low (DONE or drop).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int waits, input logic [31:0] rdata);
    bit done = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    r_stalls = 0; r_reqs = 0; r_misalign = 0; r_err = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (mem_stall) r_stalls++;
      if (bus_req) begin
        r_reqs++;
        r_we = bus_we; r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata;
        bus_ack   = (r_reqs > waits);
        bus_rdata = rdata;
      end else begin
        bus_ack = 1'b0;
      end
      if (!mem_stall) begin
        r_misalign = misalign;
        r_err      = bus_err;
        done       = 1;
      end
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (done) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("access_budget", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_stall", {31'b0, mem_stall}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_be", {28'b0, bus_be}, 32'd0);
    reset = 1'b1;

    // 1: LW zero-wait
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_addr", r_addr, 32'h100);
    check("lw_be", {28'b0, r_be}, 32'hF);
    check("lw_we", {31'b0, r_we}, 32'd0);
    check("lw_stalls", r_stalls, 32'd2);
    check("lw_data", load_data, 32'hDEADBEEF);

    // 2: sub-word loads with one wait state
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456);
    check("lb_data", load_data, 32'hFFFFFF80);
    check("lb_stalls", r_stalls, 32'd3);
    check("lb_addr", r_addr, 32'h100);
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456);
    check("lbu_data", load_data, 32'h00000080);
    run_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h80123456);
    check("lhu_data", load_data, 32'h00008012);
    run_access(1, 0, 3'b001, 32'h100, 32'h0, 0, 32'h12348001);
    check("lh_data", load_data, 32'hFFFF8001);

    // 3: stores; load_data must keep 0xFFFF8001
    run_access(1, 1, 3'b000, 32'h201, 32'h000000AB, 0, 32'h55555555);
    check("sb_we", {31'b0, r_we}, 32'd1);
    check("sb_be", {28'b0, r_be}, 32'h2);
    check("sb_wdata", r_wdata, 32'hABABABAB);
    check("sb_addr", r_addr, 32'h200);
    run_access(0, 1, 3'b001, 32'h202, 32'h00001234, 2, 32'h0);
    check("sh_be", {28'b0, r_be}, 32'hC);
    check("sh_wdata", r_wdata, 32'h12341234);
    check("sh_stalls", r_stalls, 32'd4);
    check("st_keeps_load", load_data, 32'hFFFF8001);

    // 4: dropped accesses
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h11111111);
    check("mis_pulse", {31'b0, r_misalign}, 32'd1);
    check("mis_no_req", r_reqs, 32'd0);
    check("mis_stalls", r_stalls, 32'd0);
    check("mis_keeps_load", load_data, 32'hFFFF8001);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h11111111);
    check("ill_pulse", {31'b0, r_misalign}, 32'd1);
    check("ill_no_req", r_reqs, 32'd0);

    // Ack in the final allowed cycle is a success
    run_access(1, 0, 3'b010, 32'h104, 32'h0, TMO - 1, 32'hCAFEF00D);
    check("late_ack_err", {31'b0, r_err}, 32'd0);
    check("late_ack_data", load_data, 32'hCAFEF00D);
    check("late_ack_reqs", r_reqs, TMO);

    // 5: timeout
    run_access(1, 0, 3'b010, 32'h108, 32'h0, 99, 32'h0);
    check("tmo_reqs", r_reqs, TMO);
    check("tmo_err", {31'b0, r_err}, 32'd1);
    check("tmo_stalls", r_stalls, TMO + 1);
    check("tmo_data", load_data, 32'd0);
    #1;
    check("tmo_err_pulse", {31'b0, bus_err}, 32'd0);

    // 6: async reset in the middle of REQ
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; addr = 32'h300;
    repeat (3) @(negedge clk);
    check("pre_rst_req", {31'b0, bus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, bus_req}, 32'd0);
    check("rst_mid_stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    mem_read = 0;
    reset = 1'b1;
    #1;
    check("post_rst_req", {31'b0, bus_req}, 32'd0);
    run_access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0BADCAFE);
    check("post_rst_lw", load_data, 32'h0BADCAFE);
    check("post_rst_stalls", r_stalls, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
